test_finisher: RTL and testbench
================================

TEST_FINISHER -- requirements
Module: test_finisher

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000, cycles after reset release before a timeout is declared.
REQ-002 Parameter GPIO_W, default 8, width of the status GPIO output.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst_b  input  1  reset, synchronous, active-low.
REQ-005 req_valid  input  1  bus request strobe.
REQ-006 req_write  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  4  byte address; word-aligned, bits [1:0] ignored.
REQ-008 req_wdata  input  32  write data.
REQ-009 req_ready  output  1  request accepted; tied high.
REQ-010 rsp_valid  output  1  read data valid, one cycle after an accepted read.
REQ-011 rsp_rdata  output  32  read data.
REQ-012 done  output  1  test ended (pass, fail or timeout); sticky.
REQ-013 pass  output  1  test ended with a pass.
REQ-014 fail  output  1  test ended with a fail.
REQ-015 timeout  output  1  watchdog expired before the test ended.
REQ-016 fail_num  output  31  failing test number, taken from TOHOST[31:1].
REQ-017 gpio  output  GPIO_W  {done, pass, fail, timeout, testnum[GPIO_W-5:0]}.

Function
REQ-018 Register map:
- 0x0 TOHOST: write-only; reads return 0.
- 0x4 TESTNUM: read/write, 32 bits.
- 0x8 STATUS: read-only, {28'b0, timeout, fail, pass, done}.
- 0xC CYCLE: read-only, 32 bits.
REQ-019 FSM states: RUN, PASS, FAIL, TMO. PASS, FAIL and TMO are terminal until reset.
REQ-020 In RUN, a write to TOHOST with wdata == 1 moves to PASS on the next edge.
REQ-021 In RUN, a write to TOHOST with wdata[0] == 1 and wdata[31:1] != 0 moves to FAIL and latches fail_num = wdata[31:1].
REQ-022 A TOHOST write with wdata[0] == 0 is ignored; state stays RUN.
REQ-023 In RUN, when CYCLE reaches TIMEOUT_CYCLES-1 and no ending TOHOST write occurs that cycle, the FSM moves to TMO.
REQ-024 If an ending TOHOST write and timeout expiry happen in the same cycle, the TOHOST write wins.
REQ-025 In terminal states, TOHOST writes are ignored and fail_num holds.
REQ-026 TESTNUM writes are accepted in every state.
REQ-027 CYCLE increments by 1 each cycle in RUN, saturates at 0xFFFFFFFF, and freezes in terminal states.
REQ-028 Outputs are registered and decode directly from state:
- done = state != RUN
- pass = PASS
- fail = FAIL
- timeout = TMO
REQ-029 A read returns rsp_valid = 1 with rsp_rdata one cycle after req_valid && !req_write; otherwise rsp_valid = 0.
REQ-030 Unmapped addresses do not exist within the 4-bit space; all four word offsets decode.
REQ-031 Back-to-back requests are accepted every cycle; each read produces exactly one response, in order.

Reset
REQ-032 When rst_b is low at a rising edge, the following reset together, including mid-test and in terminal states:
- state = RUN
- CYCLE = 0, TESTNUM = 0, fail_num = 0
- rsp_valid = 0, rsp_rdata = 0
- done = pass = fail = timeout = 0, gpio = 0
REQ-033 Requests presented while rst_b is low are dropped.

Configuration
REQ-034 Macro TEST_FINISHER_TIMEOUT_EN:
- Defined: the watchdog (REQ-023) is present.
- Undefined: the TMO state is unreachable and timeout is constant 0.
- CYCLE counting and the register map are unchanged in both cases.

Verification
REQ-035 Reset release, write TOHOST = 0x1 at cycle 20 -> pass = 1 and done = 1 on the next edge; STATUS reads 0x3; CYCLE reads frozen at 20.
REQ-036 Write TESTNUM = 5, then TOHOST = 0xB -> fail = 1, fail_num = 5; gpio = {1,0,1,0,TESTNUM[3:0] = 0101}.
REQ-037 No TOHOST write, macro defined, TIMEOUT_CYCLES = 50 -> timeout = 1 after 50 cycles, STATUS = 0x9; macro undefined -> timeout stays 0 after 1000 cycles.
REQ-038 TOHOST = 0x1 written in the expiry cycle -> PASS, not TMO; a later TOHOST = 0x7 -> still PASS and fail_num = 0.
REQ-039 Reach FAIL, assert rst_b = 0 for 1 cycle -> all outputs 0, CYCLE restarts at 0; TOHOST = 0x2 afterwards -> still RUN.
REQ-040 Back-to-back reads of 0x4, 0x8, 0xC on consecutive cycles -> three rsp_valid pulses in order with correct data; a TOHOST read returns 0.

Source files
------------

// File: rtl/test_finisher.sv
// Test-end register block: TOHOST/TESTNUM/STATUS/CYCLE map, pass/fail/timeout FSM.
// Optional watchdog enabled by defining TEST_FINISHER_TIMEOUT_EN.
module test_finisher #(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned GPIO_W         = 8
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [3:0]        req_addr,
  input  logic [31:0]       req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [30:0]       fail_num,
  output logic [GPIO_W-1:0] gpio
);

`ifdef TEST_FINISHER_TIMEOUT_EN
  localparam bit WDOG_EN = 1'b1;
`else
  localparam bit WDOG_EN = 1'b0;
`endif

  localparam logic [31:0] EXPIRE_AT = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {RUN, PASS, FAIL, TMO} state_t;

  state_t      state, state_nxt;
  logic [31:0] cycle_q;
  logic [31:0] testnum_q;
  logic [30:0] fail_num_q;
  logic        done_q, pass_q, fail_q, timeout_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;

  logic        wr, rd, end_wr, expire;
  logic [31:0] rdata_mux;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^req_addr[1:0];

  always_comb begin
    wr     = req_valid && req_write;
    rd     = req_valid && !req_write;
    end_wr = wr && (req_addr[3:2] == 2'd0) && req_wdata[0];
    expire = WDOG_EN && (cycle_q == EXPIRE_AT);
  end

  // An ending TOHOST write takes priority over watchdog expiry in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (end_wr)
          state_nxt = (req_wdata[31:1] == 31'd0) ? PASS : FAIL;
        else if (expire)
          state_nxt = TMO;
      end
      default: state_nxt = state;
    endcase
  end

  always_comb begin
    rdata_mux = '0;
    case (req_addr[3:2])
      2'd0: rdata_mux = '0;
      2'd1: rdata_mux = testnum_q;
      2'd2: rdata_mux = {28'd0, timeout_q, fail_q, pass_q, done_q};
      2'd3: rdata_mux = cycle_q;
      default: rdata_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state       <= RUN;
      cycle_q     <= '0;
      testnum_q   <= '0;
      fail_num_q  <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == RUN && state_nxt == FAIL)
        fail_num_q <= req_wdata[31:1];
      // CYCLE freezes on the edge that leaves RUN, so it reports the ending cycle.
      if (state_nxt == RUN && cycle_q != '1)
        cycle_q <= cycle_q + 32'd1;
      if (wr && req_addr[3:2] == 2'd1)
        testnum_q <= req_wdata;
      done_q      <= (state_nxt != RUN);
      pass_q      <= (state_nxt == PASS);
      fail_q      <= (state_nxt == FAIL);
      timeout_q   <= WDOG_EN && (state_nxt == TMO);
      rsp_valid_q <= rd;
      if (rd)
        rsp_rdata_q <= rdata_mux;
    end
  end

  assign req_ready = 1'b1;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign timeout   = timeout_q;
  assign fail_num  = fail_num_q;
  assign gpio      = {done_q, pass_q, fail_q, timeout_q, testnum_q[GPIO_W-5:0]};

endmodule

// File: tb/tb_test_finisher.sv
// Self-checking bench for test_finisher against a behavioural register/result model.
module tb_test_finisher;
  localparam int unsigned TO = 50;
`ifdef TEST_FINISHER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [3:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, rsp_valid, done, pass, fail, timeout;
  logic [31:0] rsp_rdata;
  logic [30:0] fail_num;
  logic [7:0]  gpio;

  int n_checks = 0;
  int n_pass = 0;

  test_finisher #(.TIMEOUT_CYCLES(TO), .GPIO_W(8)) dut (
    .clk(clk), .rst_b(rst_b), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .done(done), .pass(pass),
    .fail(fail), .timeout(timeout), .fail_num(fail_num), .gpio(gpio)
  );

  always #5 clk = ~clk;

  // Reference model: result 0=running 1=pass 2=fail 3=timeout
  int          m_res;
  longint      m_cycle;
  logic [31:0] m_testnum;
  logic [30:0] m_fail;
  logic        m_rv;
  logic [31:0] m_rd;

  function automatic logic [31:0] model_read(input logic [3:0] a);
    case (a / 4)
      0: return 32'd0;
      1: return m_testnum;
      2: return {28'd0, m_res == 3, m_res == 2, m_res == 1, m_res != 0};
      default: return 32'(m_cycle);
    endcase
  endfunction

  function automatic logic [7:0] model_gpio();
    return {m_res != 0, m_res == 1, m_res == 2, m_res == 3, m_testnum[3:0]};
  endfunction

  task automatic step(input logic r, input logic v, input logic w,
                      input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    rst_b = r; req_valid = v; req_write = w; req_addr = a; req_wdata = d;
    if (!r) begin
      m_res = 0; m_cycle = 0; m_testnum = 0; m_fail = 0; m_rv = 0; m_rd = 0;
    end else begin
      m_rv = v && !w;
      if (m_rv) m_rd = model_read(a);
      if (m_res == 0) begin
        if (v && w && a / 4 == 0 && d % 2 == 1) begin
          if (d == 1) m_res = 1;
          else begin m_res = 2; m_fail = d[31:1]; end
        end else if (TMO_EN && m_cycle == TO - 1) m_res = 3;
        else if (m_cycle < 64'hFFFF_FFFF) m_cycle = m_cycle + 1;
      end
      if (v && w && a / 4 == 1) m_testnum = d;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 4'h0, 32'h0);
  endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] d); step(1, 1, 1, a, d); endtask
  task automatic rd(input logic [3:0] a); step(1, 1, 0, a, 32'h0); endtask
  task automatic do_reset(); step(0, 0, 0, 4'h0, 32'h0); endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step(0, 1'($urandom), 1'($urandom), 4'($urandom), 32'h1);
    n_checks++; if ({done, pass, fail, timeout} !== 4'b0) $display("FAIL reset_flags: got %b want 0000", {done, pass, fail, timeout}); else n_pass++;
    n_checks++; if (gpio !== 8'h00) $display("FAIL reset_gpio: got %h want 00", gpio); else n_pass++;
    n_checks++; if (fail_num !== 31'd0) $display("FAIL reset_fail_num: got %h want 0", fail_num); else n_pass++;
    n_checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'd0) $display("FAIL reset_rsp: got %b/%h want 0/0", rsp_valid, rsp_rdata); else n_pass++;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL req_ready: got %b want 1", req_ready); else n_pass++;
  endtask

  task automatic test_pass();
    do_reset(); idle(20); wr(4'h0, 32'h1);
    n_checks++; if (pass !== 1'b1 || done !== 1'b1) $display("FAIL pass_flags: got pass=%b done=%b want 1/1", pass, done); else n_pass++;
    rd(4'h8);
    n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h3) $display("FAIL pass_status: got %b/%h want 1/3", rsp_valid, rsp_rdata); else n_pass++;
    idle(5); rd(4'hC);
    n_checks++; if (rsp_rdata !== 32'd20) $display("FAIL pass_cycle_frozen: got %0d want 20", rsp_rdata); else n_pass++;
  endtask

  task automatic test_fail();
    do_reset(); wr(4'h4, 32'd5); wr(4'h0, 32'hB);
    n_checks++; if (fail !== 1'b1 || pass !== 1'b0) $display("FAIL fail_flag: got fail=%b pass=%b want 1/0", fail, pass); else n_pass++;
    n_checks++; if (fail_num !== 31'd5) $display("FAIL fail_num: got %0d want 5", fail_num); else n_pass++;
    n_checks++; if (gpio !== 8'hA5) $display("FAIL fail_gpio: got %h want a5", gpio); else n_pass++;
  endtask

  task automatic test_timeout();
    do_reset();
    if (TMO_EN) begin
      idle(TO - 1);
      n_checks++; if (timeout !== 1'b0) $display("FAIL timeout_early: got %b want 0", timeout); else n_pass++;
      idle(1);
      n_checks++; if (timeout !== 1'b1 || done !== 1'b1) $display("FAIL timeout_fire: got %b/%b want 1/1", timeout, done); else n_pass++;
      rd(4'h8);
      n_checks++; if (rsp_rdata !== 32'h9) $display("FAIL timeout_status: got %h want 9", rsp_rdata); else n_pass++;
    end else begin
      idle(1000);
      n_checks++; if (timeout !== 1'b0 || done !== 1'b0) $display("FAIL no_watchdog: got %b/%b want 0/0", timeout, done); else n_pass++;
      rd(4'hC);
      n_checks++; if (rsp_rdata !== 32'd1000) $display("FAIL no_watchdog_cycle: got %0d want 1000", rsp_rdata); else n_pass++;
    end
  endtask

  task automatic test_race();
    do_reset(); idle(TO - 1); wr(4'h0, 32'h1);
    n_checks++; if (pass !== 1'b1 || timeout !== 1'b0) $display("FAIL race_pass: got pass=%b tmo=%b want 1/0", pass, timeout); else n_pass++;
    wr(4'h0, 32'h7);
    n_checks++; if (pass !== 1'b1 || fail !== 1'b0 || fail_num !== 31'd0) $display("FAIL race_hold: got %b/%b/%0d want 1/0/0", pass, fail, fail_num); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset(); wr(4'h4, 32'h3C); wr(4'h0, 32'h2F);
    n_checks++; if (fail !== 1'b1) $display("FAIL mid_reach_fail: got %b want 1", fail); else n_pass++;
    do_reset();
    n_checks++; if ({done, pass, fail, timeout, gpio, fail_num} !== '0) $display("FAIL mid_reset_clear: got %b %h %h", {done, pass, fail, timeout}, gpio, fail_num); else n_pass++;
    rd(4'hC); idle(3); rd(4'hC);
    n_checks++; if (rsp_rdata !== 32'd4) $display("FAIL mid_cycle_restart: got %0d want 4", rsp_rdata); else n_pass++;
    wr(4'h0, 32'h2);
    n_checks++; if (done !== 1'b0) $display("FAIL mid_even_ignored: got %b want 0", done); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] tn;
    tn = $urandom;
    do_reset(); wr(4'h4, tn);
    rd(4'h4);
    n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== tn) $display("FAIL b2b_testnum: got %b/%h want 1/%h", rsp_valid, rsp_rdata, tn); else n_pass++;
    rd(4'h8);
    n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0) $display("FAIL b2b_status: got %b/%h want 1/0", rsp_valid, rsp_rdata); else n_pass++;
    rd(4'hC);
    n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'd3) $display("FAIL b2b_cycle: got %b/%0d want 1/3", rsp_valid, rsp_rdata); else n_pass++;
    rd(4'h3);
    n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0) $display("FAIL b2b_tohost_read: got %b/%h want 1/0", rsp_valid, rsp_rdata); else n_pass++;
    idle(1);
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL b2b_idle: got %b want 0", rsp_valid); else n_pass++;
  endtask

  task automatic test_random();
    int errs;
    logic [31:0] d;
    errs = 0;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0: d = 32'h1;
        1: d = {31'($urandom), 1'b1};
        2: d = {31'($urandom), 1'b0};
        default: d = $urandom;
      endcase
      step(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) == 0), 1'($urandom), 4'($urandom), d);
      if (rsp_valid !== m_rv || rsp_rdata !== m_rd || done !== (m_res != 0) || pass !== (m_res == 1) ||
          fail !== (m_res == 2) || timeout !== (m_res == 3) || fail_num !== m_fail || gpio !== model_gpio()) begin
        if (errs < 5)
          $display("FAIL random_cycle_%0d: got rv=%b rd=%h flags=%b fn=%h gpio=%h want rv=%b rd=%h res=%0d fn=%h gpio=%h",
                   i, rsp_valid, rsp_rdata, {done, pass, fail, timeout}, fail_num, gpio, m_rv, m_rd, m_res, m_fail, model_gpio());
        errs++;
      end
    end
    n_checks++; if (errs != 0) $display("FAIL random_total: got %0d bad cycles want 0", errs); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_timeout();
    test_race();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
